fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h8000_0180, meaning PC loaded on misaligned-target trap (used only with MISALIGN_TRAP_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Jump, Jal, BranchEQ, BranchNE, JumpReg  input  1 each  decoded control for the instruction in ISSUE.
REQ-006 Zero  input  1  ALU equality result for the instruction in ISSUE.
REQ-007 BranchOffset  input  32  sign-extended immediate, in words.
REQ-008 JumpAddr  input  26  J-format target field.
REQ-009 RegAddr  input  32  rs value for JR.
REQ-010 Stall  input  1  holds the instruction in ISSUE.
REQ-011 imem_ack, imem_rdata  input  1, 32  instruction-memory response, data valid when imem_ack=1.
REQ-012 imem_req, imem_addr  output  1, 32  instruction-memory request and word address.
REQ-013 PC, PC_4  output  32 each  current PC and PC+4.
REQ-014 Instruction, InstrValid  output  32, 1  fetched word and its valid flag.
REQ-015 LinkAddr  output  32  return address for JAL, written to $ra.
REQ-016 Trap  output  1  misaligned-target indication (tied 0 without MISALIGN_TRAP_EN).

Function
REQ-017 FSM states SHALL be IDLE, FETCH, ISSUE, plus TRAP with MISALIGN_TRAP_EN.
REQ-018 IDLE -> FETCH unconditionally after one cycle.
REQ-019 FETCH: imem_req=1, imem_addr=PC; on imem_ack latch imem_rdata into Instruction, go to ISSUE; ack in cycle 0 of FETCH accepted (min latency 1 cycle from req to ISSUE).
REQ-020 imem_ack outside FETCH SHALL be ignored.
REQ-021 ISSUE: InstrValid=1, Instruction held stable; Stall=1 remains in ISSUE with PC unchanged.
REQ-022 ISSUE with Stall=0: PC <= next PC, go to FETCH.
REQ-023 Next-PC priority: JumpReg -> RegAddr; else Jump or Jal -> {PC_4[31:28], JumpAddr, 2'b00}; else (BranchEQ&Zero)|(BranchNE&~Zero) -> PC_4 + (BranchOffset<<2); else PC_4.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
REQ-025 LinkAddr SHALL equal PC_4 combinationally whenever InstrValid=1, else 0.
REQ-026 BranchEQ and BranchNE both asserted SHALL follow REQ-023 literally (always taken).
REQ-027 Control inputs outside ISSUE SHALL have no effect.

Reset
REQ-028 reset=1 at a clock edge SHALL force state IDLE, PC=RESET_PC, Instruction=0, InstrValid=0, imem_req=0, Trap=0, regardless of current state.
REQ-029 Reset during FETCH SHALL abandon the request; imem_req low the cycle after; late ack ignored.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN defined: JR target with RegAddr[1:0]!=0 in ISSUE (Stall=0) SHALL go to TRAP, Trap=1, PC=TRAP_PC; TRAP -> FETCH after one cycle, Trap high exactly that one cycle.
REQ-031 Macro undefined: target bits [1:0] SHALL be forced to 2'b00; no TRAP state; Trap tied 0.

Structure
REQ-032 State encodings, RESET_PC/TRAP_PC defaults and field widths (26-bit jump field, 32-bit word) SHALL live in shared package mips_pkg.
REQ-033 Next-PC selection SHALL be a combinational sub-module next_pc_logic; FSM and registers stay in fetch_unit.

Verification
REQ-034 Reset, ack after 1 cycle -> imem_addr=0x0040_0000, then PC=0x0040_0004 after ISSUE with no control.
REQ-035 PC=0x0040_0010, BranchEQ=1, Zero=1, BranchOffset=-2 -> next PC 0x0040_000C; Zero=0 -> 0x0040_0014.
REQ-036 PC=0x0040_0020, Jal=1, JumpAddr=26'h010_0040 -> LinkAddr=0x0040_0024, next PC 0x0040_0100.
REQ-037 Stall=1 for 3 ISSUE cycles -> PC and Instruction unchanged, imem_req=0, then advances one step.
REQ-038 reset asserted in FETCH with ack following -> InstrValid stays 0, PC=RESET_PC.
REQ-039 JumpReg=1, RegAddr=0x0040_0102 -> with MISALIGN_TRAP_EN Trap pulse, PC=0x8000_0180; without, PC=0x0040_0100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM state encoding,
// reset/trap vector defaults and the architectural field widths.
// Optional feature macro: MISALIGN_TRAP_EN adds the StTrap state.
package mips_pkg;

  localparam int unsigned WordW      = 32;
  localparam int unsigned JumpFieldW = 26;

  typedef logic [WordW-1:0]      word_t;
  typedef logic [JumpFieldW-1:0] jump_field_t;

  localparam word_t ResetPcDef = 32'h0040_0000;
  localparam word_t TrapPcDef  = 32'h8000_0180;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StTrap} fetch_state_e;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StIssue} fetch_state_e;
`endif

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus used by the fetch unit.
//   imem_req   : fetch request, held for the whole FETCH state
//   imem_addr  : byte address of the word being fetched (the current PC)
//   imem_ack   : response strobe, imem_rdata valid in the same cycle
//   imem_rdata : returned instruction word
// master = fetch unit side, slave = memory side.
interface fetch_unit_if;
  import mips_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the instruction in ISSUE.
// Priority: register jump > J/JAL > taken branch > sequential.
//   jump, jal, branch_eq, branch_ne, jump_reg, zero : decoded control / ALU flag
//   branch_offset : sign-extended word offset
//   jump_addr     : J-format target field
//   reg_addr      : rs value for JR
//   pc_4          : current PC + 4
//   next_pc       : selected successor PC (word aligned)
module next_pc_logic
  import mips_pkg::*;
(
  input  logic        jump,
  input  logic        jal,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump_reg,
  input  logic        zero,
  input  word_t       branch_offset,
  input  jump_field_t jump_addr,
  input  word_t       reg_addr,
  input  word_t       pc_4,
  output word_t       next_pc
);

  logic branch_taken;

  // Both branch flags together is simply "taken" regardless of zero.
  assign branch_taken = (branch_eq & zero) | (branch_ne & ~zero);

  always_comb begin
    next_pc = pc_4;
    if (jump_reg) begin
      // Low bits dropped; a misaligned JR is diverted to the trap path upstream
      // when that feature is built in, so the mask never hides it there.
      next_pc = reg_addr & 32'hFFFF_FFFC;
    end else if (jump || jal) begin
      next_pc = {pc_4[31:28], jump_addr, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_4 + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> ISSUE loop with PC register.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned JR target traps to TRAP_PC).
//   clk, reset        : clock, synchronous active-high reset
//   Jump..JumpReg,Zero: control for the instruction in ISSUE
//   BranchOffset, JumpAddr, RegAddr : branch/jump operands
//   Stall             : hold the instruction in ISSUE
//   bus               : instruction-memory interface (master)
//   PC, PC_4          : current PC and PC+4
//   Instruction, InstrValid : fetched word and its valid flag
//   LinkAddr          : JAL return address (PC_4 while valid, else 0)
//   Trap              : one-cycle misaligned-target indication
module fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = ResetPcDef,
  parameter word_t TRAP_PC  = TrapPcDef
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Jump,
  input  logic                Jal,
  input  logic                BranchEQ,
  input  logic                BranchNE,
  input  logic                JumpReg,
  input  logic                Zero,
  input  word_t               BranchOffset,
  input  jump_field_t         JumpAddr,
  input  word_t               RegAddr,
  input  logic                Stall,
  fetch_unit_if.master        bus,
  output word_t               PC,
  output word_t               PC_4,
  output word_t               Instruction,
  output logic                InstrValid,
  output word_t               LinkAddr,
  output logic                Trap
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  word_t        next_pc;

  next_pc_logic u_next_pc (
    .jump          (Jump),
    .jal           (Jal),
    .branch_eq     (BranchEQ),
    .branch_ne     (BranchNE),
    .jump_reg      (JumpReg),
    .zero          (Zero),
    .branch_offset (BranchOffset),
    .jump_addr     (JumpAddr),
    .reg_addr      (RegAddr),
    .pc_4          (PC_4),
    .next_pc       (next_pc)
  );

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = JumpReg && (RegAddr[1:0] != 2'b00);
`else
  logic unused_trap_pc;
  assign unused_trap_pc = ^TRAP_PC;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!Stall) begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            pc_d    = TRAP_PC;
            state_d = StTrap;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
`else
          pc_d    = next_pc;
          state_d = StFetch;
`endif
        end
      end
`ifdef MISALIGN_TRAP_EN
      StTrap:  state_d = StFetch;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign bus.imem_req  = (state_q == StFetch);
  assign bus.imem_addr = pc_q;
  assign PC            = pc_q;
  assign PC_4          = pc_q + 32'd4;
  assign Instruction   = instr_q;
  assign InstrValid    = (state_q == StIssue);
  assign LinkAddr      = InstrValid ? PC_4 : '0;

`ifdef MISALIGN_TRAP_EN
  assign Trap = (state_q == StTrap);
`else
  assign Trap = 1'b0;
`endif

endmodule
